// File: rtl/pc_unit_pkg.sv
// Shared types and defaults for the program-counter unit: FSM state
// encoding, next-PC source select and default widths.
package pc_unit_pkg;

  localparam int PC_NB_DEFAULT        = 32;
  localparam int PC_STEP_DEFAULT      = 4;
  localparam int PC_RAS_DEPTH_DEFAULT = 4;

  typedef enum logic {
    PC_ST_RUN    = 1'b0,
    PC_ST_HALTED = 1'b1
  } pc_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_RAS    = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/pc_unit_if.sv
// Control/redirect inputs and status outputs of the PC unit. The master
// side is the debug/stall/redirect logic; the slave side is pc_unit.
interface pc_unit_if
  import pc_unit_pkg::*;
#(
  parameter int NB = PC_NB_DEFAULT
);
  logic          i_enable;
  logic          i_enable_pc;
  logic          i_branch_taken;
  logic [NB-1:0] i_branch_target;
  logic          i_jump;
  logic [NB-1:0] i_jump_target;
  logic          i_call;
  logic          i_return;
  logic          i_halt;
  logic          i_resume;
  logic [NB-1:0] o_pc_mem;
  logic [NB-1:0] o_pc_seq;
  logic          o_halted;
  logic          o_ras_empty;
  logic          o_ras_underflow;
  logic          o_ras_overflow;
  logic [NB-1:0] o_adv_count;
  logic          o_misaligned;

  modport master (
    output i_enable, i_enable_pc, i_branch_taken, i_branch_target,
           i_jump, i_jump_target, i_call, i_return, i_halt, i_resume,
    input  o_pc_mem, o_pc_seq, o_halted, o_ras_empty, o_ras_underflow,
           o_ras_overflow, o_adv_count, o_misaligned
  );

  modport slave (
    input  i_enable, i_enable_pc, i_branch_taken, i_branch_target,
           i_jump, i_jump_target, i_call, i_return, i_halt, i_resume,
    output o_pc_mem, o_pc_seq, o_halted, o_ras_empty, o_ras_underflow,
           o_ras_overflow, o_adv_count, o_misaligned
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry and sets the sticky overflow flag. Push and pop together replace
// the top entry in place; a pop on an empty stack is a no-op, so a
// push+pop on an empty stack degenerates to a plain push.
module pc_ras
  import pc_unit_pkg::*;
#(
  parameter int NB    = PC_NB_DEFAULT,
  parameter int DEPTH = PC_RAS_DEPTH_DEFAULT
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [NB-1:0] din,
  output logic [NB-1:0] top,
  output logic          empty,
  output logic          overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [NB-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_top;
  logic [CW-1:0] count;
  logic          do_pop;

  assign ptr_top = ptr - PW'(1);
  assign top     = mem[ptr_top];
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;

  // Entry storage; contents after reset are don't-care so no reset here.
  always_ff @(posedge clk) begin
    if (push) mem[do_pop ? ptr_top : ptr] <= din;
  end

  // Pointer, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (push && do_pop) begin
      ptr   <= ptr;
      count <= count;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count == FULL_CNT) overflow <= 1'b1;
      else                   count    <= count + CW'(1);
    end else if (do_pop) begin
      ptr   <= ptr_top;
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with branch/jump/return next-PC selection, a
// return-address stack, RUN/HALTED control and an advance counter.
// Optional macro PC_ALIGN_CHECK_EN: mask loaded targets to PC_STEP
// alignment and pulse o_misaligned when the unmasked target was off.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int            NB           = PC_NB_DEFAULT,
  parameter int            PC_STEP      = PC_STEP_DEFAULT,
  parameter logic [NB-1:0] RESET_VECTOR = '0,
  parameter int            RAS_DEPTH    = PC_RAS_DEPTH_DEFAULT
)(
  input  logic    i_clock,
  input  logic    i_reset_n,
  pc_unit_if.slave bus
);
  localparam logic [NB-1:0] STEP = NB'(PC_STEP);

  pc_state_t     state_q, state_d;
  pc_sel_t       sel;
  logic [NB-1:0] pc_q, pc_seq, target, pc_next, cnt_q, ras_top;
  logic          adv, ret, ras_push, ras_pop, ras_empty, ras_overflow;
  logic          underflow_q;

  assign pc_seq   = pc_q + STEP;
  assign adv      = bus.i_enable & bus.i_enable_pc & (state_q == PC_ST_RUN);
  // A taken branch squashes any RAS side effect of the same cycle.
  assign ret      = bus.i_jump & bus.i_return & ~bus.i_branch_taken;
  assign ras_push = adv & bus.i_jump & bus.i_call & ~bus.i_branch_taken;
  assign ras_pop  = adv & ret;

  pc_ras #(.NB(NB), .DEPTH(RAS_DEPTH)) u_ras (
    .clk      (i_clock),
    .rst_n    (i_reset_n),
    .push     (ras_push),
    .pop      (ras_pop),
    .din      (pc_seq),
    .top      (ras_top),
    .empty    (ras_empty),
    .overflow (ras_overflow)
  );

  // Next-PC source priority: branch, RAS return, jump, sequential.
  always_comb begin
    sel = SEL_SEQ;
    if (bus.i_branch_taken)     sel = SEL_BRANCH;
    else if (ret && !ras_empty) sel = SEL_RAS;
    else if (bus.i_jump)        sel = SEL_JUMP;
  end

  // Next-PC mux.
  always_comb begin
    target = pc_seq;
    case (sel)
      SEL_BRANCH: target = bus.i_branch_target;
      SEL_JUMP:   target = bus.i_jump_target;
      SEL_RAS:    target = ras_top;
      default:    target = pc_seq;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [NB-1:0] ALIGN_MASK = STEP - NB'(1);
  logic misaligned_q;

  assign pc_next          = target & ~ALIGN_MASK;
  assign bus.o_misaligned = misaligned_q;

  // One-cycle flag registered together with the masked load.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) misaligned_q <= 1'b0;
    else            misaligned_q <= adv & (|(target & ALIGN_MASK));
  end
`else
  assign pc_next          = target;
  assign bus.o_misaligned = 1'b0;
`endif

  // PC, advance counter and underflow pulse.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q        <= RESET_VECTOR;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= ras_pop & ras_empty;
      if (adv) begin
        pc_q  <= pc_next;
        cnt_q <= cnt_q + NB'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= PC_ST_RUN;
    else            state_q <= state_d;
  end

  // FSM next state: halt only on an advancing cycle, resume needs enable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PC_ST_RUN:    if (adv && bus.i_halt) state_d = PC_ST_HALTED;
      PC_ST_HALTED: if (bus.i_enable && bus.i_resume) state_d = PC_ST_RUN;
      default:      state_d = PC_ST_RUN;
    endcase
  end

  assign bus.o_pc_mem        = pc_q;
  assign bus.o_pc_seq        = pc_seq;
  assign bus.o_halted        = (state_q == PC_ST_HALTED);
  assign bus.o_ras_empty     = ras_empty;
  assign bus.o_ras_underflow = underflow_q;
  assign bus.o_ras_overflow  = ras_overflow;
  assign bus.o_adv_count     = cnt_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (default parameters).
module tb_pc_unit;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  pc_unit_if #(.NB(32)) bus ();

  pc_unit #(.NB(32), .PC_STEP(4), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.i_enable        = 1'b1;
    bus.i_enable_pc     = 1'b1;
    bus.i_branch_taken  = 1'b0;
    bus.i_branch_target = 32'h0;
    bus.i_jump          = 1'b0;
    bus.i_jump_target   = 32'h0;
    bus.i_call          = 1'b0;
    bus.i_return        = 1'b0;
    bus.i_halt          = 1'b0;
    bus.i_resume        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic jump_to(input logic [31:0] t, input logic call, input logic ret);
    bus.i_jump = 1'b1; bus.i_jump_target = t; bus.i_call = call; bus.i_return = ret;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #3;
    tests_run++; if (bus.o_pc_mem !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h want %h", bus.o_pc_mem, 32'h0); end
    tests_run++; if (bus.o_adv_count !== 32'h0) begin tests_failed++; $display("FAIL reset_cnt got %h want %h", bus.o_adv_count, 32'h0); end
    tests_run++; if ({bus.o_halted, bus.o_ras_empty, bus.o_ras_underflow, bus.o_ras_overflow, bus.o_misaligned} !== 5'b01000) begin
      tests_failed++; $display("FAIL reset_flags got %b want %b", {bus.o_halted, bus.o_ras_empty, bus.o_ras_underflow, bus.o_ras_overflow, bus.o_misaligned}, 5'b01000); end
    tests_run++; if (bus.o_pc_seq !== 32'h4) begin tests_failed++; $display("FAIL reset_pc_seq got %h want %h", bus.o_pc_seq, 32'h4); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    tests_run++; if (bus.o_pc_mem !== 32'h4) begin tests_failed++; $display("FAIL seq1 got %h want %h", bus.o_pc_mem, 32'h4); end
    step();
    tests_run++; if (bus.o_pc_mem !== 32'h8) begin tests_failed++; $display("FAIL seq2 got %h want %h", bus.o_pc_mem, 32'h8); end
    step();
    tests_run++; if (bus.o_pc_mem !== 32'hC) begin tests_failed++; $display("FAIL seq3 got %h want %h", bus.o_pc_mem, 32'hC); end
    tests_run++; if (bus.o_adv_count !== 32'd3) begin tests_failed++; $display("FAIL seq_cnt got %0d want %0d", bus.o_adv_count, 3); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.o_pc_mem !== 32'h0) begin tests_failed++; $display("FAIL async_reset_pc got %h want %h", bus.o_pc_mem, 32'h0); end
    tests_run++; if (bus.o_adv_count !== 32'h0) begin tests_failed++; $display("FAIL async_reset_cnt got %h want %h", bus.o_adv_count, 32'h0); end
    rst_n = 1'b1;
  endtask

  task automatic test_stall();
    do_reset();
    bus.i_enable_pc = 1'b0; bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h80;
    step(); step();
    tests_run++; if (bus.o_pc_mem !== 32'h0) begin tests_failed++; $display("FAIL stall_pc got %h want %h", bus.o_pc_mem, 32'h0); end
    tests_run++; if (bus.o_adv_count !== 32'h0) begin tests_failed++; $display("FAIL stall_cnt got %h want %h", bus.o_adv_count, 32'h0); end
    bus.i_enable_pc = 1'b1;
    step();
    idle();
    tests_run++; if (bus.o_pc_mem !== 32'h80) begin tests_failed++; $display("FAIL stall_release_pc got %h want %h", bus.o_pc_mem, 32'h80); end
    tests_run++; if (bus.o_adv_count !== 32'h1) begin tests_failed++; $display("FAIL stall_release_cnt got %h want %h", bus.o_adv_count, 32'h1); end
    bus.i_enable = 1'b0; bus.i_jump = 1'b1; bus.i_jump_target = 32'h500; bus.i_call = 1'b1;
    step();
    idle();
    tests_run++; if (bus.o_pc_mem !== 32'h80) begin tests_failed++; $display("FAIL disable_pc got %h want %h", bus.o_pc_mem, 32'h80); end
    tests_run++; if (bus.o_ras_empty !== 1'b1) begin tests_failed++; $display("FAIL disable_ras got %b want %b", bus.o_ras_empty, 1'b1); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h100;
    bus.i_jump = 1'b1; bus.i_call = 1'b1; bus.i_jump_target = 32'h200;
    step();
    tests_run++; if (bus.o_pc_mem !== 32'h100) begin tests_failed++; $display("FAIL br_pri_pc got %h want %h", bus.o_pc_mem, 32'h100); end
    tests_run++; if (bus.o_ras_empty !== 1'b1) begin tests_failed++; $display("FAIL br_pri_ras got %b want %b", bus.o_ras_empty, 1'b1); end
    bus.i_branch_target = 32'h300; bus.i_call = 1'b0; bus.i_return = 1'b1; bus.i_jump_target = 32'h500;
    step();
    idle();
    tests_run++; if (bus.o_pc_mem !== 32'h300) begin tests_failed++; $display("FAIL br_ret_pc got %h want %h", bus.o_pc_mem, 32'h300); end
    tests_run++; if (bus.o_ras_underflow !== 1'b0) begin tests_failed++; $display("FAIL br_ret_unf got %b want %b", bus.o_ras_underflow, 1'b0); end
    bus.i_call = 1'b1; bus.i_return = 1'b1;
    step();
    idle();
    tests_run++; if (bus.o_pc_mem !== 32'h304) begin tests_failed++; $display("FAIL nojump_pc got %h want %h", bus.o_pc_mem, 32'h304); end
    tests_run++; if ({bus.o_ras_empty, bus.o_ras_underflow} !== 2'b10) begin tests_failed++; $display("FAIL nojump_ras got %b want %b", {bus.o_ras_empty, bus.o_ras_underflow}, 2'b10); end
  endtask

  task automatic test_call_return();
    do_reset();
    jump_to(32'h10, 1'b0, 1'b0);
    tests_run++; if (bus.o_pc_mem !== 32'h10) begin tests_failed++; $display("FAIL j_pc got %h want %h", bus.o_pc_mem, 32'h10); end
    jump_to(32'h40, 1'b1, 1'b0);
    tests_run++; if (bus.o_pc_mem !== 32'h40) begin tests_failed++; $display("FAIL jal_pc got %h want %h", bus.o_pc_mem, 32'h40); end
    tests_run++; if (bus.o_ras_empty !== 1'b0) begin tests_failed++; $display("FAIL jal_ras got %b want %b", bus.o_ras_empty, 1'b0); end
    jump_to(32'h999, 1'b0, 1'b1);
    tests_run++; if (bus.o_pc_mem !== 32'h14) begin tests_failed++; $display("FAIL jr_pc got %h want %h", bus.o_pc_mem, 32'h14); end
    tests_run++; if ({bus.o_ras_empty, bus.o_ras_underflow} !== 2'b10) begin tests_failed++; $display("FAIL jr_ras got %b want %b", {bus.o_ras_empty, bus.o_ras_underflow}, 2'b10); end
    // call+return on a non-empty stack: return to top, replace it with link
    jump_to(32'h40, 1'b1, 1'b0);
    jump_to(32'h80, 1'b1, 1'b1);
    tests_run++; if (bus.o_pc_mem !== 32'h18) begin tests_failed++; $display("FAIL callret_pc got %h want %h", bus.o_pc_mem, 32'h18); end
    jump_to(32'h999, 1'b0, 1'b1);
    tests_run++; if (bus.o_pc_mem !== 32'h44) begin tests_failed++; $display("FAIL callret_pop got %h want %h", bus.o_pc_mem, 32'h44); end
    tests_run++; if (bus.o_ras_empty !== 1'b1) begin tests_failed++; $display("FAIL callret_empty got %b want %b", bus.o_ras_empty, 1'b1); end
    // call+return on an empty stack: take jump target, underflow, then push
    jump_to(32'h60, 1'b1, 1'b1);
    tests_run++; if (bus.o_pc_mem !== 32'h60) begin tests_failed++; $display("FAIL callret_e_pc got %h want %h", bus.o_pc_mem, 32'h60); end
    tests_run++; if ({bus.o_ras_empty, bus.o_ras_underflow} !== 2'b01) begin tests_failed++; $display("FAIL callret_e_ras got %b want %b", {bus.o_ras_empty, bus.o_ras_underflow}, 2'b01); end
    jump_to(32'h999, 1'b0, 1'b1);
    tests_run++; if (bus.o_pc_mem !== 32'h48) begin tests_failed++; $display("FAIL callret_e_pop got %h want %h", bus.o_pc_mem, 32'h48); end
  endtask

  task automatic test_overflow();
    logic [31:0] links [4];
    links[0] = 32'h404; links[1] = 32'h304; links[2] = 32'h204; links[3] = 32'h104;
    do_reset();
    for (int i = 1; i <= 4; i++) jump_to(32'(i) << 8, 1'b1, 1'b0);
    tests_run++; if (bus.o_ras_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_full got %b want %b", bus.o_ras_overflow, 1'b0); end
    jump_to(32'h500, 1'b1, 1'b0);
    tests_run++; if (bus.o_ras_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set got %b want %b", bus.o_ras_overflow, 1'b1); end
    for (int i = 0; i < 4; i++) begin
      jump_to(32'h700, 1'b0, 1'b1);
      tests_run++; if (bus.o_pc_mem !== links[i]) begin tests_failed++; $display("FAIL ovf_pop%0d got %h want %h", i, bus.o_pc_mem, links[i]); end
    end
    tests_run++; if (bus.o_ras_empty !== 1'b1) begin tests_failed++; $display("FAIL ovf_empty got %b want %b", bus.o_ras_empty, 1'b1); end
    jump_to(32'h700, 1'b0, 1'b1);
    tests_run++; if (bus.o_pc_mem !== 32'h700) begin tests_failed++; $display("FAIL unf_pc got %h want %h", bus.o_pc_mem, 32'h700); end
    tests_run++; if (bus.o_ras_underflow !== 1'b1) begin tests_failed++; $display("FAIL unf_pulse got %b want %b", bus.o_ras_underflow, 1'b1); end
    step();
    tests_run++; if ({bus.o_ras_underflow, bus.o_ras_overflow} !== 2'b01) begin tests_failed++; $display("FAIL unf_clear got %b want %b", {bus.o_ras_underflow, bus.o_ras_overflow}, 2'b01); end
    tests_run++; if (bus.o_pc_mem !== 32'h704) begin tests_failed++; $display("FAIL unf_next got %h want %h", bus.o_pc_mem, 32'h704); end
  endtask

  task automatic test_halt();
    do_reset();
    jump_to(32'h20, 1'b0, 1'b0);
    bus.i_halt = 1'b1;
    step();
    idle();
    tests_run++; if (bus.o_pc_mem !== 32'h24) begin tests_failed++; $display("FAIL halt_pc got %h want %h", bus.o_pc_mem, 32'h24); end
    tests_run++; if (bus.o_halted !== 1'b1) begin tests_failed++; $display("FAIL halt_state got %b want %b", bus.o_halted, 1'b1); end
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++; if (bus.o_pc_mem !== 32'h24) begin tests_failed++; $display("FAIL halt_hold%0d got %h want %h", i, bus.o_pc_mem, 32'h24); end
    end
    tests_run++; if (bus.o_adv_count !== 32'd2) begin tests_failed++; $display("FAIL halt_cnt got %0d want %0d", bus.o_adv_count, 2); end
    bus.i_enable = 1'b0; bus.i_resume = 1'b1;
    step();
    tests_run++; if (bus.o_halted !== 1'b1) begin tests_failed++; $display("FAIL resume_disabled got %b want %b", bus.o_halted, 1'b1); end
    bus.i_enable = 1'b1;
    step();
    idle();
    tests_run++; if ({bus.o_halted, bus.o_pc_mem} !== {1'b0, 32'h24}) begin tests_failed++; $display("FAIL resume_cycle got %b/%h want 0/%h", bus.o_halted, bus.o_pc_mem, 32'h24); end
    step();
    tests_run++; if (bus.o_pc_mem !== 32'h28) begin tests_failed++; $display("FAIL resume_next got %h want %h", bus.o_pc_mem, 32'h28); end
  endtask

  task automatic test_wrap_align();
    do_reset();
    jump_to(32'hFFFF_FFFC, 1'b0, 1'b0);
    step();
    tests_run++; if (bus.o_pc_mem !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc got %h want %h", bus.o_pc_mem, 32'h0); end
    jump_to(32'h43, 1'b0, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
    tests_run++; if ({bus.o_misaligned, bus.o_pc_mem} !== {1'b1, 32'h40}) begin tests_failed++; $display("FAIL align_load got %b/%h want 1/%h", bus.o_misaligned, bus.o_pc_mem, 32'h40); end
    step();
    tests_run++; if ({bus.o_misaligned, bus.o_pc_mem} !== {1'b0, 32'h44}) begin tests_failed++; $display("FAIL align_next got %b/%h want 0/%h", bus.o_misaligned, bus.o_pc_mem, 32'h44); end
`else
    tests_run++; if ({bus.o_misaligned, bus.o_pc_mem} !== {1'b0, 32'h43}) begin tests_failed++; $display("FAIL noalign_load got %b/%h want 0/%h", bus.o_misaligned, bus.o_pc_mem, 32'h43); end
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    test_reset();
    test_stall();
    test_branch_priority();
    test_call_return();
    test_overflow();
    test_halt();
    test_wrap_align();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
